// File: rtl/fp_result_scroller_pkg.sv
// Shared definitions for the FP result scroller: FSM encodings, display constants
// and the byte selector used to walk a latched 32-bit result MSB-first.
package fp_result_scroller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHOW   = 2'd1,
    ST_GAP    = 2'd2,
    ST_UNUSED = 2'd3
  } state_e;

  localparam logic [7:0] BLANK_BYTE = 8'h00;
  localparam logic [1:0] MSB_INDEX  = 2'd3;

  // Index 3 is bits [31:24], index 0 is bits [7:0].
  function automatic logic [7:0] select_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] sel;
    case (idx)
      2'd3:    sel = word[31:24];
      2'd2:    sel = word[23:16];
      2'd1:    sel = word[15:8];
      default: sel = word[7:0];
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/fp_result_scroller_if.sv
// Valid/ready handshake carrying one 32-bit FP adder result into the scroller.
interface fp_result_scroller_if;
  logic [31:0] result_in;
  logic        result_valid;
  logic        result_ready;

  modport master (output result_in, output result_valid, input  result_ready);
  modport slave  (input  result_in, input  result_valid, output result_ready);
endinterface

// File: rtl/fp_result_scroller_dwell_timer.sv
// Dwell counter: counts 0..DWELL_CYCLES-1, flags the terminal count and restarts,
// or restarts immediately when cleared by a load.
module dwell_timer #(
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int CNT_W        = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DWELL_CYCLES - 1);

  logic [CNT_W-1:0] dwell_cnt;

  assign tick = (dwell_cnt == TERMINAL);

  // NOTE: sequential state uses non-blocking assignments and an async reset in the
  // sensitivity list so every flop updates from pre-edge values and clears without a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dwell_cnt <= '0;
    end else if (clear || tick) begin
      dwell_cnt <= '0;
    end else begin
      dwell_cnt <= dwell_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fp_result_scroller.sv
// Latches an FP result on handshake and scrolls it MSB byte first onto the display
// data bus, one byte per dwell period followed by a blank gap, repeating until reloaded.
module fp_result_scroller
  import fp_result_scroller_pkg::*;
#(
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int CNT_W        = 26
) (
  input  logic                       clk,
  input  logic                       reset,
  fp_result_scroller_if.slave        bus,
  output logic [7:0]                 data_out,
  output logic [1:0]                 byte_index,
  output logic                       busy
);

  typedef struct packed {
    state_e      state;
    logic [31:0] held;
    logic [7:0]  data;
    logic [1:0]  idx;
  } regs_t;

  localparam regs_t RESET_REGS = '{
    state: ST_IDLE,
    held:  32'h0,
    data:  BLANK_BYTE,
    idx:   2'd0
  };

  regs_t r;
  regs_t r_nxt;
  logic  ready;
  logic  transfer;
  logic  tick;
  logic  timer_clear;

  assign ready      = (r.state == ST_IDLE) || (r.state == ST_GAP);
  assign transfer   = bus.result_valid && ready;

  assign bus.result_ready = ready;
  assign data_out         = r.data;
  assign byte_index       = r.idx;
  assign busy             = (r.state == ST_SHOW);

  dwell_timer #(
    .DWELL_CYCLES (DWELL_CYCLES),
    .CNT_W        (CNT_W)
  ) u_dwell_timer (
    .clk   (clk),
    .reset (reset),
    .clear (timer_clear),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r <= RESET_REGS;
    end else begin
      r <= r_nxt;
    end
  end

  // NOTE: every output of this block gets a default first so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    r_nxt       = r;
    timer_clear = 1'b0;

    case (r.state)
      ST_IDLE: begin
        timer_clear = 1'b1;
        r_nxt.data  = BLANK_BYTE;
        r_nxt.idx   = 2'd0;
        if (transfer) begin
          r_nxt.state = ST_SHOW;
          r_nxt.held  = bus.result_in;
          r_nxt.idx   = MSB_INDEX;
          r_nxt.data  = select_byte(bus.result_in, MSB_INDEX);
        end
      end

      ST_SHOW: begin
        if (tick) begin
          if (r.idx != 2'd0) begin
            r_nxt.idx  = r.idx - 2'd1;
            r_nxt.data = select_byte(r.held, r.idx - 2'd1);
          end else begin
            r_nxt.state = ST_GAP;
            r_nxt.data  = BLANK_BYTE;
            r_nxt.idx   = 2'd0;
          end
        end
      end

      ST_GAP: begin
        // A new result cuts the gap short and also wins over the loop restart.
        if (transfer) begin
          timer_clear = 1'b1;
          r_nxt.state = ST_SHOW;
          r_nxt.held  = bus.result_in;
          r_nxt.idx   = MSB_INDEX;
          r_nxt.data  = select_byte(bus.result_in, MSB_INDEX);
        end else if (tick) begin
          r_nxt.state = ST_SHOW;
          r_nxt.idx   = MSB_INDEX;
          r_nxt.data  = select_byte(r.held, MSB_INDEX);
        end
      end

      default: begin
        timer_clear = 1'b1;
        r_nxt       = RESET_REGS;
      end
    endcase
  end

endmodule

// File: tb/tb_fp_result_scroller.sv
// Directed bench for fp_result_scroller: DWELL_CYCLES=4 instance for the main
// scenarios plus a DWELL_CYCLES=1 instance for the single-cycle dwell case.
module tb_fp_result_scroller;

  logic clk;
  logic reset;

  fp_result_scroller_if bus4 ();
  fp_result_scroller_if bus1 ();

  logic [7:0] data4, data1;
  logic [1:0] bi4, bi1;
  logic       busy4, busy1;

  int tests_run;
  int tests_failed;

  fp_result_scroller #(.DWELL_CYCLES(4), .CNT_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus4),
    .data_out   (data4),
    .byte_index (bi4),
    .busy       (busy4)
  );

  fp_result_scroller #(.DWELL_CYCLES(1), .CNT_W(1)) dut_one (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus1),
    .data_out   (data1),
    .byte_index (bi1),
    .busy       (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (data4 !== 8'h00) begin tests_failed++; $display("FAIL reset data_out: got %h expected 00", data4); end
    tests_run++;
    if (bi4 !== 2'd0) begin tests_failed++; $display("FAIL reset byte_index: got %0d expected 0", bi4); end
    tests_run++;
    if (busy4 !== 1'b0) begin tests_failed++; $display("FAIL reset busy: got %b expected 0", busy4); end
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus4.result_ready !== 1'b1) begin tests_failed++; $display("FAIL release ready: got %b expected 1", bus4.result_ready); end
    tests_run++;
    if (data4 !== 8'h00) begin tests_failed++; $display("FAIL release data_out: got %h expected 00", data4); end
  endtask

  // Load pi in IDLE; walk 40,49,0F,DB (4 cycles each), gap 00 x4, then 40 again.
  task automatic test_scroll;
    logic [7:0] exp_data [6] = '{8'h40, 8'h49, 8'h0F, 8'hDB, 8'h00, 8'h40};
    logic [1:0] exp_bi   [6] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd3};
    int ph;
    bus4.result_in    = 32'h40490FDB;
    bus4.result_valid = 1'b1;
    @(negedge clk);
    bus4.result_valid = 1'b0;
    bus4.result_in    = 32'hDEADBEEF;
    for (int i = 0; i <= 20; i++) begin
      if (i > 0) @(negedge clk);
      ph = i / 4;
      tests_run++;
      if (data4 !== exp_data[ph]) begin tests_failed++; $display("FAIL scroll data cyc %0d: got %h expected %h", i, data4, exp_data[ph]); end
      tests_run++;
      if (bi4 !== exp_bi[ph]) begin tests_failed++; $display("FAIL scroll byte_index cyc %0d: got %0d expected %0d", i, bi4, exp_bi[ph]); end
      tests_run++;
      if (busy4 !== (ph != 4)) begin tests_failed++; $display("FAIL scroll busy cyc %0d: got %b expected %b", i, busy4, ph != 4); end
      tests_run++;
      if (bus4.result_ready !== (ph == 4)) begin tests_failed++; $display("FAIL scroll ready cyc %0d: got %b expected %b", i, bus4.result_ready, ph == 4); end
    end
  endtask

  // Starts at 40 dwell offset 0 of the second loop; valid held high through SHOW.
  task automatic test_valid_during_show;
    logic [7:0] exp_data [4] = '{8'h40, 8'h49, 8'h0F, 8'hDB};
    int o;
    bus4.result_in    = 32'h3F800000;
    bus4.result_valid = 1'b1;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      o = j + 1;
      tests_run++;
      if (data4 !== exp_data[o / 4]) begin tests_failed++; $display("FAIL hold_valid data off %0d: got %h expected %h", o, data4, exp_data[o / 4]); end
      tests_run++;
      if (bus4.result_ready !== 1'b0) begin tests_failed++; $display("FAIL hold_valid ready off %0d: got %b expected 0", o, bus4.result_ready); end
    end
    @(negedge clk);
    tests_run++;
    if (data4 !== 8'h00) begin tests_failed++; $display("FAIL hold_valid gap data: got %h expected 00", data4); end
    tests_run++;
    if (bus4.result_ready !== 1'b1) begin tests_failed++; $display("FAIL hold_valid gap ready: got %b expected 1", bus4.result_ready); end
    @(negedge clk);
    bus4.result_valid = 1'b0;
    tests_run++;
    if (data4 !== 8'h3F) begin tests_failed++; $display("FAIL hold_valid accept data: got %h expected 3f", data4); end
    tests_run++;
    if (bi4 !== 2'd3) begin tests_failed++; $display("FAIL hold_valid accept byte_index: got %0d expected 3", bi4); end
  endtask

  // 3F800000 shows for 16 cycles, gap for 4; transfer on the gap's terminal edge.
  task automatic test_gap_terminal;
    int steps = 0;
    while (busy4 === 1'b1 && steps < 40) begin
      @(negedge clk);
      steps++;
    end
    tests_run++;
    if (steps != 16) begin tests_failed++; $display("FAIL gap_term show length: got %0d expected 16", steps); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests_run++;
      if (data4 !== 8'h00) begin tests_failed++; $display("FAIL gap_term gap data %0d: got %h expected 00", k, data4); end
      tests_run++;
      if (bus4.result_ready !== 1'b1) begin tests_failed++; $display("FAIL gap_term gap ready %0d: got %b expected 1", k, bus4.result_ready); end
    end
    bus4.result_in    = 32'hC0000000;
    bus4.result_valid = 1'b1;
    @(negedge clk);
    bus4.result_valid = 1'b0;
    tests_run++;
    if (data4 !== 8'hC0) begin tests_failed++; $display("FAIL gap_term new data: got %h expected c0", data4); end
    tests_run++;
    if (bi4 !== 2'd3) begin tests_failed++; $display("FAIL gap_term byte_index: got %0d expected 3", bi4); end
  endtask

  task automatic test_reset_mid_show;
    repeat (4) @(negedge clk);
    tests_run++;
    if (bi4 !== 2'd2) begin tests_failed++; $display("FAIL mid_reset pre byte_index: got %0d expected 2", bi4); end
    tests_run++;
    if (busy4 !== 1'b1) begin tests_failed++; $display("FAIL mid_reset pre busy: got %b expected 1", busy4); end
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if (data4 !== 8'h00) begin tests_failed++; $display("FAIL mid_reset async data: got %h expected 00", data4); end
    tests_run++;
    if (bi4 !== 2'd0) begin tests_failed++; $display("FAIL mid_reset async byte_index: got %0d expected 0", bi4); end
    tests_run++;
    if (busy4 !== 1'b0) begin tests_failed++; $display("FAIL mid_reset async busy: got %b expected 0", busy4); end
    @(negedge clk);
    reset = 1'b1;
    bus4.result_in = 32'hFFFFFFFF;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      tests_run++;
      if (data4 !== 8'h00) begin tests_failed++; $display("FAIL mid_reset idle data %0d: got %h expected 00", k, data4); end
      tests_run++;
      if (busy4 !== 1'b0) begin tests_failed++; $display("FAIL mid_reset idle busy %0d: got %b expected 0", k, busy4); end
      tests_run++;
      if (bus4.result_ready !== 1'b1) begin tests_failed++; $display("FAIL mid_reset idle ready %0d: got %b expected 1", k, bus4.result_ready); end
    end
  endtask

  task automatic test_dwell_one;
    logic [7:0] exp_data [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h01};
    logic [1:0] exp_bi   [6] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd3};
    bus1.result_in    = 32'h01020304;
    bus1.result_valid = 1'b1;
    @(negedge clk);
    bus1.result_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      tests_run++;
      if (data1 !== exp_data[i]) begin tests_failed++; $display("FAIL dwell1 data cyc %0d: got %h expected %h", i, data1, exp_data[i]); end
      tests_run++;
      if (bi1 !== exp_bi[i]) begin tests_failed++; $display("FAIL dwell1 byte_index cyc %0d: got %0d expected %0d", i, bi1, exp_bi[i]); end
    end
  endtask

  initial begin
    tests_run         = 0;
    tests_failed      = 0;
    reset             = 1'b0;
    bus4.result_in    = 32'h0;
    bus4.result_valid = 1'b0;
    bus1.result_in    = 32'h0;
    bus1.result_valid = 1'b0;

    test_reset();
    test_scroll();
    test_valid_during_show();
    test_gap_terminal();
    test_reset_mid_show();
    test_dwell_one();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
